// File: rtl/line_bank_sched.sv
// Line bank scheduler: hands two line buffers back and forth between the
// video input writer and the scaler reader, one full line at a time, and
// sequences each frame through sync, run and drain phases.
module line_bank_sched (
    input  logic        vin_clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] vin_xres,
    input  logic [15:0] vin_yres,
    input  logic        wr_valid,
    input  logic [15:0] vin_wr_x,
    input  logic [15:0] vin_wr_y,
    input  logic        rd_req,
    input  logic        rd_done,
    output logic        frame_sync_n,
    output logic        vout_ready,
    output logic        wr_en,
    output logic        wr_bank,
    output logic [15:0] wr_addr,
    output logic        rd_grant,
    output logic        rd_bank,
    output logic [15:0] rd_line_y,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN,
        ST_DRAIN
    } frame_state_t;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_t;

    frame_state_t state;
    frame_state_t state_nxt;
    bank_state_t  bank_st     [2];
    bank_state_t  bank_st_nxt [2];
    logic [15:0]  bank_line   [2];
    logic         wp;
    logic         rp;
    logic         wp_nxt;
    logic         rp_nxt;

    logic wr_target_open;
    logic line_end;
    logic frame_end;
    logic overrun;
    logic rd_take;
    logic rd_release;
    logic drain_done;
    logic vout_ready_nxt;

    // Decode the per-cycle events: legal writes, line/frame ends, overruns,
    // read grants and releases, and drain completion.
    always_comb begin
        wr_target_open = (bank_st[wp] == BANK_FREE) || (bank_st[wp] == BANK_FILLING);
        wr_en          = wr_valid && (state == ST_RUN) && wr_target_open;
        wr_bank        = wp;
        wr_addr        = vin_wr_x;
        line_end       = wr_en && (vin_wr_x == (vin_xres - 16'd1));
        frame_end      = line_end && (vin_wr_y == (vin_yres - 16'd1));
        overrun        = wr_valid && (state == ST_RUN) && !wr_target_open;
        rd_take        = rd_req && ((state == ST_RUN) || (state == ST_DRAIN))
                         && (bank_st[rp] == BANK_FULL);
        rd_release     = rd_done && (bank_st[rp] == BANK_READING);
        drain_done     = (state == ST_DRAIN) && (bank_st[0] == BANK_FREE)
                         && (bank_st[1] == BANK_FREE);
    end

    // Next frame state, bank states and pointers; writer and reader never
    // touch the same bank in one cycle, so their updates are independent.
    always_comb begin
        state_nxt      = state;
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        wp_nxt         = wp;
        rp_nxt         = rp;

        case (state)
            ST_IDLE:  if (frame_start) state_nxt = ST_SYNC;
            ST_SYNC:  state_nxt = ST_RUN;
            ST_RUN:   if (frame_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        if (wr_en) begin
            if (line_end) begin
                bank_st_nxt[wp] = BANK_FULL;
                wp_nxt          = ~wp;
            end else if (bank_st[wp] == BANK_FREE) begin
                bank_st_nxt[wp] = BANK_FILLING;
            end
        end

        if (rd_take) begin
            bank_st_nxt[rp] = BANK_READING;
        end

        if (rd_release) begin
            bank_st_nxt[rp] = BANK_FREE;
            rp_nxt          = ~rp;
        end

        if (((state == ST_IDLE) && frame_start) || (state == ST_SYNC)) begin
            bank_st_nxt[0] = BANK_FREE;
            bank_st_nxt[1] = BANK_FREE;
            wp_nxt         = 1'b0;
            rp_nxt         = 1'b0;
        end

        vout_ready_nxt = (state_nxt == ST_RUN)
                         && ((bank_st_nxt[wp_nxt] == BANK_FREE)
                             || (bank_st_nxt[wp_nxt] == BANK_FILLING));
    end

    // Register the frame FSM, bank bookkeeping and all status outputs.
    always_ff @(posedge vin_clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bank_st[0]   <= BANK_FREE;
            bank_st[1]   <= BANK_FREE;
            bank_line[0] <= 16'd0;
            bank_line[1] <= 16'd0;
            wp           <= 1'b0;
            rp           <= 1'b0;
            frame_sync_n <= 1'b1;
            vout_ready   <= 1'b0;
            rd_grant     <= 1'b0;
            rd_bank      <= 1'b0;
            rd_line_y    <= 16'd0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            bank_st[0]   <= bank_st_nxt[0];
            bank_st[1]   <= bank_st_nxt[1];
            wp           <= wp_nxt;
            rp           <= rp_nxt;
            if (line_end) begin
                bank_line[wp] <= vin_wr_y;
            end
            frame_sync_n <= (state_nxt != ST_SYNC);
            vout_ready   <= vout_ready_nxt;
            rd_grant     <= rd_take;
            if (rd_take) begin
                rd_bank   <= rp;
                rd_line_y <= bank_line[rp];
            end
            frame_done   <= drain_done;
            if ((frame_start && (state != ST_IDLE)) || overrun) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_bank_sched.sv
// Directed testbench for line_bank_sched. Expected read grants are queued
// when a request is issued; a monitor pops and compares on every rd_grant.
module tb_line_bank_sched;

    logic        vin_clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] vin_xres = 16'd4;
    logic [15:0] vin_yres = 16'd2;
    logic        wr_valid = 1'b0;
    logic [15:0] vin_wr_x = 16'd0;
    logic [15:0] vin_wr_y = 16'd0;
    logic        rd_req = 1'b0;
    logic        rd_done = 1'b0;
    logic        frame_sync_n;
    logic        vout_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [15:0] wr_addr;
    logic        rd_grant;
    logic        rd_bank;
    logic [15:0] rd_line_y;
    logic        frame_done;
    logic        frame_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_seen = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_exp;

    line_bank_sched dut (
        .vin_clk      (vin_clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .vin_xres     (vin_xres),
        .vin_yres     (vin_yres),
        .wr_valid     (wr_valid),
        .vin_wr_x     (vin_wr_x),
        .vin_wr_y     (vin_wr_y),
        .rd_req       (rd_req),
        .rd_done      (rd_done),
        .frame_sync_n (frame_sync_n),
        .vout_ready   (vout_ready),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .rd_grant     (rd_grant),
        .rd_bank      (rd_bank),
        .rd_line_y    (rd_line_y),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    // 10 ns clock
    always #5 vin_clk = ~vin_clk;

    // Drive one cycle of inputs just after the rising edge, then wait for the
    // falling edge so the caller can sample outputs mid-cycle.
    task automatic applyStimulus(input logic r, input logic fs, input logic wv,
                                 input logic [15:0] x, input logic [15:0] y,
                                 input logic rq, input logic rd);
        @(posedge vin_clk);
        #1;
        rst         = r;
        frame_start = fs;
        wr_valid    = wv;
        vin_wr_x    = x;
        vin_wr_y    = y;
        rd_req      = rq;
        rd_done     = rd;
        @(negedge vin_clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic write_px(input logic [15:0] x, input logic [15:0] y);
        applyStimulus(1'b0, 1'b0, 1'b1, x, y, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every grant must match the oldest queued expectation.
    always @(negedge vin_clk) begin
        if (rd_grant === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("[TB] FAIL unexpected_grant: got bank %0d line %0d, expected no grant at %0t",
                         rd_bank, rd_line_y, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rd_bank, rd_line_y} !== mon_exp) begin
                    n_errors++;
                    $display("[TB] FAIL grant: got bank %0d line %0d, expected bank %0d line %0d at %0t",
                             rd_bank, rd_line_y, mon_exp[16], mon_exp[15:0], $time);
                end
            end
        end
        if (frame_done === 1'b1) begin
            done_seen++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        idle();
        checkOutput("rst_sync_n", frame_sync_n, 16'd1);
        checkOutput("rst_ready", vout_ready, 16'd0);
        checkOutput("rst_grant", rd_grant, 16'd0);
        checkOutput("rst_done", frame_done, 16'd0);
        checkOutput("rst_err", frame_err, 16'd0);

        // Frame xres=4 yres=2, reader serves both lines
        $display("[TB] frame 4x2");
        vin_xres = 16'd4;
        vin_yres = 16'd2;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        checkOutput("idle_sync_n", frame_sync_n, 16'd1);
        idle();
        checkOutput("sync_n_low", frame_sync_n, 16'd0);
        checkOutput("sync_ready", vout_ready, 16'd0);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                write_px(16'(x), 16'(y));
                checkOutput("f1_wr_en", wr_en, 16'd1);
                checkOutput("f1_wr_bank", wr_bank, 16'(y));
                checkOutput("f1_wr_addr", wr_addr, 16'(x));
                checkOutput("f1_ready", vout_ready, 16'd1);
                checkOutput("f1_sync_n", frame_sync_n, 16'd1);
            end
        end
        exp_q.push_back({1'b0, 16'd0});
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("drain_ready", vout_ready, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        exp_q.push_back({1'b1, 16'd1});
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        idle();
        checkOutput("f1_done_early", frame_done, 16'd0);
        idle();
        checkOutput("f1_done_pulse", frame_done, 16'd1);
        idle();
        checkOutput("f1_done_end", frame_done, 16'd0);
        checkOutput("f1_done_count", 16'(done_seen), 16'd1);

        // Frame xres=4 yres=4 with no reader: overrun, then one bank freed
        $display("[TB] frame 4x4 overrun");
        vin_yres = 16'd4;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        idle();
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                write_px(16'(x), 16'(y));
                checkOutput("f2_wr_en", wr_en, 16'd1);
            end
        end
        write_px(16'd0, 16'd2);
        checkOutput("full_ready", vout_ready, 16'd0);
        checkOutput("overrun_wr_en", wr_en, 16'd0);
        checkOutput("err_before", frame_err, 16'd0);
        idle();
        checkOutput("overrun_err", frame_err, 16'd1);
        exp_q.push_back({1'b0, 16'd0});
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("reading_ready", vout_ready, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        checkOutput("release_ready", vout_ready, 16'd0);
        write_px(16'd0, 16'd2);
        checkOutput("freed_ready", vout_ready, 16'd1);
        checkOutput("freed_wr_en", wr_en, 16'd1);
        checkOutput("freed_wr_bank", wr_bank, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        write_px(16'd1, 16'd2);
        checkOutput("f2_rst_err", frame_err, 16'd0);
        checkOutput("f2_rst_wr_en", wr_en, 16'd0);

        // Frame xres=1 yres=3: every pixel ends a line
        $display("[TB] frame 1x3");
        vin_xres = 16'd1;
        vin_yres = 16'd3;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        idle();
        write_px(16'd0, 16'd0);
        checkOutput("x1_wr_en0", wr_en, 16'd1);
        checkOutput("x1_wr_bank0", wr_bank, 16'd0);
        exp_q.push_back({1'b0, 16'd0});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 1'b1, 1'b0);
        checkOutput("x1_wr_bank1", wr_bank, 16'd1);
        checkOutput("x1_ready1", vout_ready, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        checkOutput("x1_ready_blocked", vout_ready, 16'd0);
        exp_q.push_back({1'b1, 16'd1});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 16'd2, 1'b1, 1'b0);
        checkOutput("x1_ready_freed", vout_ready, 16'd1);
        checkOutput("x1_wr_bank2", wr_bank, 16'd0);
        checkOutput("x1_wr_en2", wr_en, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        checkOutput("x1_drain_ready", vout_ready, 16'd0);
        exp_q.push_back({1'b0, 16'd2});
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        idle();
        checkOutput("x1_done_early", frame_done, 16'd0);
        idle();
        checkOutput("x1_done_pulse", frame_done, 16'd1);
        idle();
        checkOutput("x1_done_count", 16'(done_seen), 16'd2);

        // Frame xres=2: restart attempt in RUN, coincident release and line end
        $display("[TB] frame 2x4 concurrency");
        vin_xres = 16'd2;
        vin_yres = 16'd4;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        idle();
        write_px(16'd0, 16'd0);
        write_px(16'd1, 16'd0);
        exp_q.push_back({1'b0, 16'd0});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 1'b1, 1'b0);
        checkOutput("c_wr_bank1", wr_bank, 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        checkOutput("c_err_before", frame_err, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b0, 1'b1);
        checkOutput("c_restart_err", frame_err, 16'd1);
        checkOutput("c_restart_sync_n", frame_sync_n, 16'd1);
        checkOutput("c_ready", vout_ready, 16'd1);
        checkOutput("c_wr_en_end", wr_en, 16'd1);
        exp_q.push_back({1'b1, 16'd1});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 16'd2, 1'b1, 1'b0);
        checkOutput("c_ready_after", vout_ready, 16'd1);
        checkOutput("c_wp_toggled", wr_bank, 16'd0);
        checkOutput("c_wr_en_next", wr_en, 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        checkOutput("c_grant_pre_rst", rd_line_y, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b1);
        checkOutput("mid_rst_sync_n", frame_sync_n, 16'd1);
        checkOutput("mid_rst_ready", vout_ready, 16'd0);
        checkOutput("mid_rst_grant", rd_grant, 16'd0);
        checkOutput("mid_rst_bank", rd_bank, 16'd0);
        checkOutput("mid_rst_line", rd_line_y, 16'd0);
        checkOutput("mid_rst_done", frame_done, 16'd0);
        checkOutput("mid_rst_err", frame_err, 16'd0);
        checkOutput("mid_rst_wr_en", wr_en, 16'd0);
        idle();
        checkOutput("idle_no_grant", rd_grant, 16'd0);

        // Reset during the sync cycle wins over entering RUN
        $display("[TB] reset in sync");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        checkOutput("rs_sync_low", frame_sync_n, 16'd0);
        idle();
        checkOutput("rs_sync_n", frame_sync_n, 16'd1);
        checkOutput("rs_ready", vout_ready, 16'd0);
        idle();
        checkOutput("rs_ready_idle", vout_ready, 16'd0);
        checkOutput("rs_sync_idle", frame_sync_n, 16'd1);

        checkOutput("grants_pending", 16'(exp_q.size()), 16'd0);
        checkOutput("done_total", 16'(done_seen), 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_bank_sched.md
LINE_BANK_SCHED -- requirements
Module: line_bank_sched

Interface
REQ-001 SHALL have ports: vin_clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: frame_start  in  1  one-cycle request to begin a frame.
REQ-004 SHALL have ports: vin_xres, vin_yres  in  16 each  active pixels per line and lines per frame, both >=1, stable while frame active.
REQ-005 SHALL have ports: wr_valid  in  1; vin_wr_x, vin_wr_y  in  16 each  pixel write strobe and coordinates from the input controller.
REQ-006 SHALL have ports: rd_req  in  1  scaler asks for a full line; rd_done  in  1  scaler releases the line it holds.
REQ-007 SHALL have ports: frame_sync_n  out  1  active-low counter clear to the input controller; vout_ready  out  1  registered write-permission to the input controller.
REQ-008 SHALL have ports: wr_en  out  1; wr_bank  out  1; wr_addr  out  16  line-buffer write port, combinational from wr_valid/vin_wr_x and the write pointer.
REQ-009 SHALL have ports: rd_grant  out  1  one-cycle pulse; rd_bank  out  1; rd_line_y  out  16  bank and line number granted.
REQ-010 SHALL have ports: frame_done  out  1  one-cycle pulse; frame_err  out  1  sticky error flag.

Function
REQ-011 SHALL manage two line banks (0,1), each in state FREE, FILLING, FULL or READING, with a 1-bit write pointer wp and read pointer rp.
REQ-012 SHALL run a frame FSM IDLE -> SYNC -> RUN -> DRAIN -> IDLE.
REQ-013 IDLE: frame_start moves to SYNC; all else ignored.
REQ-014 SYNC lasts exactly one cycle: frame_sync_n=0 in that cycle, both banks FREE, wp=rp=0; then RUN.
REQ-015 frame_sync_n SHALL be 1 in every state except SYNC.
REQ-016 wr_en = wr_valid AND state in {RUN} AND bank[wp] in {FREE,FILLING}; wr_bank=wp; wr_addr=vin_wr_x.
REQ-017 wr_en with bank[wp]=FREE SHALL set bank[wp]=FILLING.
REQ-018 wr_en with vin_wr_x = vin_xres-1 SHALL set bank[wp]=FULL, latch vin_wr_y as that bank's line number, toggle wp; xres=1 goes FREE->FULL in one cycle.
REQ-019 wr_en on a line end with vin_wr_y = vin_yres-1 SHALL move RUN -> DRAIN.
REQ-020 vout_ready SHALL be registered: 1 in the cycle after an edge whose next state is RUN and whose next bank[next wp] is FREE or FILLING; else 0.
REQ-021 rd_req with bank[rp]=FULL in RUN or DRAIN SHALL set bank[rp]=READING, pulse rd_grant one cycle later with rd_bank=rp and rd_line_y=latched line number; rd_req otherwise ignored (not queued).
REQ-022 rd_done with bank[rp]=READING SHALL set bank[rp]=FREE and toggle rp; rd_done otherwise ignored.
REQ-023 Write update and rd_done on different banks in the same cycle SHALL both take effect; a bank freed at edge t is writable (vout_ready=1) from t+1.
REQ-024 DRAIN with both banks FREE SHALL go to IDLE and pulse frame_done for one cycle.
REQ-025 frame_start in SYNC, RUN or DRAIN SHALL be ignored and set frame_err; frame_err cleared only by rst.
REQ-026 wr_valid while bank[wp] is FULL or READING (writer overrun) SHALL set frame_err and not write.
REQ-027 Line numbers and comparisons SHALL use full 16-bit unsigned arithmetic; vin_xres-1 and vin_yres-1 never wrap since inputs >=1.

Reset
REQ-028 rst SHALL force, on the next edge: FSM=IDLE, both banks FREE, wp=rp=0, frame_sync_n=1, vout_ready=0, rd_grant=0, rd_bank=0, rd_line_y=0, frame_done=0, frame_err=0.
REQ-029 rst SHALL take priority over every other input, including mid-frame and during SYNC.

Verification
REQ-030 xres=4, yres=2, frame_start, reader always ready -> frame_sync_n low 1 cycle, vout_ready high next cycle, rd_grant with rd_line_y=0 then 1, frame_done once after second rd_done.
REQ-031 xres=4, yres=4, no rd_req -> banks 0,1 FULL after 8 pixels, vout_ready=0 from cycle after 8th write; extra wr_valid -> frame_err=1, wr_en=0.
REQ-032 Both banks FULL, rd_req+rd_done on bank 0 -> vout_ready returns 1 one cycle after rd_done, next line written to bank 0.
REQ-033 xres=1, yres=3 -> each pixel completes a line, wp toggles every write, rd_line_y sequence 0,1,2.
REQ-034 frame_start during RUN -> ignored, frame_err=1; rst mid-frame -> all outputs at REQ-028 values next cycle.
REQ-035 rd_done on a READING bank coincident with a line end on the other bank -> both banks updated, both pointers toggle.
